// File: rtl/lfsr_pattern_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pattern_checker_if
// Description : Valid/ready pattern stream between an LFSR pattern source
//               (generator or pattern-memory readback) and the checker.
//               pat_data is indexed [0:7]; index 0 is the MSB (leftmost bit).
// Ports       : pat_valid  source -> checker, pattern present
//               pat_data   source -> checker, 8-bit pattern
//               pat_ready  checker -> source, pattern accepted this cycle
// Revision    : 1.0  initial release
// ============================================================================
interface lfsr_pattern_checker_if;
    logic       pat_valid;
    logic [0:7] pat_data;
    logic       pat_ready;

    modport master (
        output pat_valid,
        output pat_data,
        input  pat_ready
    );

    modport slave (
        input  pat_valid,
        input  pat_data,
        output pat_ready
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pattern_checker
// Description : Consumer side of the LFSR pattern generator. Predicts each
//               next pattern from the latched tap set, counts matches and
//               mismatches, accumulates consecutive-pattern Hamming distance
//               and reports lock / fail status.
// Ports       : clk, rst_n   clock (rising edge), async active-low reset
//               tap_cfg      tap set, latched by cfg_load while IDLE
//               cfg_load     latch tap_cfg (IDLE only)
//               start        IDLE -> ACQUIRE
//               clear        synchronous return to IDLE, clears counters
//               pat          pattern stream (slave side)
//               state_o      00 IDLE, 01 ACQUIRE, 10 CHECK, 11 FAIL
//               match_cnt    patterns equal to the prediction
//               err_cnt      patterns differing from the prediction
//               hd_sum       running sum of consecutive Hamming distances
//               last_hd      Hamming distance of the most recent pair
//               locked       match run >= LOCK_RUN while checking
//               fail         high while in FAIL
// Revision    : 1.0  initial release
// ============================================================================
module lfsr_pattern_checker #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_ERR  = 3,
    parameter int unsigned LOCK_RUN = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic [6:0]            tap_cfg,
    input  wire logic                  cfg_load,
    input  wire logic                  start,
    input  wire logic                  clear,
    lfsr_pattern_checker_if.slave      pat,
    output logic [1:0]                 state_o,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [CNT_W-1:0]           hd_sum,
    output logic [3:0]                 last_hd,
    output logic                       locked,
    output logic                       fail
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ACQUIRE = 2'b01,
        S_CHECK   = 2'b10,
        S_FAIL    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_max_err  = CNT_W'(MAX_ERR);
    localparam logic [7:0]       c_lock_run = 8'(LOCK_RUN);

    state_t           r_state;
    logic [6:0]       r_tap;
    logic [0:7]       r_expected;
    logic [0:7]       r_prev;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_hd_sum;
    logic [3:0]       r_last_hd;
    logic [7:0]       r_run;
    logic             r_locked;
    logic             r_fail;

    logic             w_ready;
    logic             w_accept;
    logic             w_is_match;
    logic [0:7]       w_pred;
    logic [3:0]       w_hd;
    logic [CNT_W:0]   w_hd_wide;
    logic [CNT_W-1:0] w_hd_sum_next;
    logic [CNT_W-1:0] w_match_next;
    logic [CNT_W-1:0] w_err_next;
    logic [7:0]       w_run_next;

    // Next pattern of the generator: shift toward index 7, the bit leaving
    // index 7 re-enters at index 0 and is XORed into every tapped position.
    function automatic logic [0:7] f_next(input logic [0:7] p, input logic [6:0] t);
        logic [0:7] n;
        n[0] = p[7];
        for (int i = 1; i < 8; i++) begin
            n[i] = p[i-1] ^ (t[7-i] & p[7]);
        end
        return n;
    endfunction

    function automatic logic [3:0] f_popcount(input logic [0:7] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Ready is the only combinational output; clear blocks acceptance in the
    // same cycle so a pattern is never half-consumed by a clearing edge.
    assign w_ready  = ((r_state == S_ACQUIRE) || (r_state == S_CHECK)) && !clear;
    assign w_accept = pat.pat_valid && w_ready;

    always_comb begin
        w_pred        = f_next(pat.pat_data, r_tap);
        w_is_match    = (pat.pat_data == r_expected);
        w_hd          = f_popcount(pat.pat_data ^ r_prev);
        w_hd_wide     = {1'b0, r_hd_sum} + (CNT_W+1)'(w_hd);
        w_hd_sum_next = w_hd_wide[CNT_W] ? {CNT_W{1'b1}} : w_hd_wide[CNT_W-1:0];
        w_match_next  = w_is_match ? f_sat_inc(r_match_cnt) : r_match_cnt;
        w_err_next    = w_is_match ? r_err_cnt : f_sat_inc(r_err_cnt);
        if (!w_is_match) begin
            w_run_next = 8'd0;
        end else if (r_run == 8'hFF) begin
            w_run_next = r_run;
        end else begin
            w_run_next = r_run + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tap       <= 7'd0;
            r_expected  <= 8'd0;
            r_prev      <= 8'd0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
            r_hd_sum    <= '0;
            r_last_hd   <= 4'd0;
            r_run       <= 8'd0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
        end else if (clear) begin
            // Tap register deliberately survives clear.
            r_state     <= S_IDLE;
            r_expected  <= 8'd0;
            r_prev      <= 8'd0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
            r_hd_sum    <= '0;
            r_last_hd   <= 4'd0;
            r_run       <= 8'd0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_tap <= tap_cfg;
                    end
                    if (start) begin
                        r_state <= S_ACQUIRE;
                    end
                end
                S_ACQUIRE: begin
                    // First pattern only seeds the predictor.
                    if (w_accept) begin
                        r_expected <= w_pred;
                        r_prev     <= pat.pat_data;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        // Prediction always follows the received pattern so a
                        // single corrupted word costs exactly one error.
                        r_expected  <= w_pred;
                        r_prev      <= pat.pat_data;
                        r_match_cnt <= w_match_next;
                        r_err_cnt   <= w_err_next;
                        r_hd_sum    <= w_hd_sum_next;
                        r_last_hd   <= w_hd;
                        r_run       <= w_run_next;
                        if (w_err_next == c_max_err) begin
                            r_state  <= S_FAIL;
                            r_locked <= 1'b0;
                            r_fail   <= 1'b1;
                        end else begin
                            r_locked <= (w_run_next >= c_lock_run);
                        end
                    end
                end
                S_FAIL: begin
                    r_fail <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pat.pat_ready = w_ready;
    assign state_o       = r_state;
    assign match_cnt     = r_match_cnt;
    assign err_cnt       = r_err_cnt;
    assign hd_sum        = r_hd_sum;
    assign last_hd       = r_last_hd;
    assign locked        = r_locked;
    assign fail          = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_pattern_checker
// Description : Directed, table-driven bench for lfsr_pattern_checker.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_pattern_checker;

    logic        clk;
    logic        rst_n;
    logic [6:0]  tap_cfg;
    logic        cfg_load;
    logic        start;
    logic        clear;
    logic [1:0]  state_o;
    logic [15:0] match_cnt;
    logic [15:0] err_cnt;
    logic [15:0] hd_sum;
    logic [3:0]  last_hd;
    logic        locked;
    logic        fail;

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_pattern_checker_if u_if ();

    lfsr_pattern_checker #(
        .CNT_W   (16),
        .MAX_ERR (3),
        .LOCK_RUN(4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tap_cfg  (tap_cfg),
        .cfg_load (cfg_load),
        .start    (start),
        .clear    (clear),
        .pat      (u_if.slave),
        .state_o  (state_o),
        .match_cnt(match_cnt),
        .err_cnt  (err_cnt),
        .hd_sum   (hd_sum),
        .last_hd  (last_hd),
        .locked   (locked),
        .fail     (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  st;
        logic [15:0] m;
        logic [15:0] e;
        logic [15:0] hs;
        logic [3:0]  lh;
        logic        lk;
        logic        fl;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [15:0] m,
                           input logic [15:0] e, input logic [15:0] hs, input logic [3:0] lh,
                           input logic lk, input logic fl);
        chk({tag, " state"},   32'(state_o),   32'(st));
        chk({tag, " match"},   32'(match_cnt), 32'(m));
        chk({tag, " err"},     32'(err_cnt),   32'(e));
        chk({tag, " hd_sum"},  32'(hd_sum),    32'(hs));
        chk({tag, " last_hd"}, 32'(last_hd),   32'(lh));
        chk({tag, " locked"},  32'(locked),    32'(lk));
        chk({tag, " fail"},    32'(fail),      32'(fl));
    endtask

    // One-cycle control pulse applied between clock edges.
    task automatic pulse(input logic ld, input logic [6:0] tap, input logic st, input logic clr);
        @(negedge clk);
        cfg_load = ld;
        tap_cfg  = tap;
        start    = st;
        clear    = clr;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        u_if.pat_valid = 1'b1;
        u_if.pat_data  = d;
        @(posedge clk);
        #1;
        u_if.pat_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'b00000001, 2'b10, 16'd0, 16'd0, 16'd0,  4'd0, 1'b0, 1'b0};
        vecs[1] = '{8'b10000001, 2'b10, 16'd1, 16'd0, 16'd1,  4'd1, 1'b0, 1'b0};
        vecs[2] = '{8'b11000001, 2'b10, 16'd2, 16'd0, 16'd2,  4'd1, 1'b0, 1'b0};
        vecs[3] = '{8'b11100001, 2'b10, 16'd3, 16'd0, 16'd3,  4'd1, 1'b0, 1'b0};
        vecs[4] = '{8'b11110001, 2'b10, 16'd4, 16'd0, 16'd4,  4'd1, 1'b1, 1'b0};
        vecs[5] = '{8'b00000000, 2'b10, 16'd4, 16'd1, 16'd9,  4'd5, 1'b0, 1'b0};
        vecs[6] = '{8'b00000000, 2'b10, 16'd5, 16'd1, 16'd9,  4'd0, 1'b0, 1'b0};
        vecs[7] = '{8'b11111111, 2'b10, 16'd5, 16'd2, 16'd17, 4'd8, 1'b0, 1'b0};
        vecs[8] = '{8'b00000000, 2'b11, 16'd5, 16'd3, 16'd25, 4'd8, 1'b0, 1'b1};

        rst_n          = 1'b0;
        tap_cfg        = 7'd0;
        cfg_load       = 1'b0;
        start          = 1'b0;
        clear          = 1'b0;
        u_if.pat_valid = 1'b0;
        u_if.pat_data  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        #1;
        chk_all("reset", 2'b00, 16'd0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0);
        chk("reset ready", 32'(u_if.pat_ready), 32'd0);

        // pat_valid held in IDLE: nothing accepted
        @(negedge clk);
        u_if.pat_valid = 1'b1;
        u_if.pat_data  = 8'b10101010;
        repeat (3) @(posedge clk);
        #1;
        chk("idle ready", 32'(u_if.pat_ready), 32'd0);
        chk_all("idle hold", 2'b00, 16'd0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0);
        u_if.pat_valid = 1'b0;

        // cfg_load and start together: tap latched and ACQUIRE entered
        pulse(1'b1, 7'b0000001, 1'b1, 1'b0);
        chk("start state", 32'(state_o), 32'd1);
        chk("acquire ready", 32'(u_if.pat_ready), 32'd1);

        // Seed, match, lock, mismatch/resync, fail
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].data);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].m, vecs[i].e,
                    vecs[i].hs, vecs[i].lh, vecs[i].lk, vecs[i].fl);
            chk($sformatf("vec%0d ready", i), 32'(u_if.pat_ready),
                32'(vecs[i].st == 2'b10));
        end

        // FAIL ignores further patterns
        for (int i = 0; i < 3; i++) begin
            send(8'b01010101);
        end
        chk_all("fail frozen", 2'b11, 16'd5, 16'd3, 16'd25, 4'd8, 1'b0, 1'b1);
        chk("fail ready", 32'(u_if.pat_ready), 32'd0);

        // clear leaves FAIL with counters zeroed
        pulse(1'b0, 7'd0, 1'b0, 1'b1);
        chk_all("clear", 2'b00, 16'd0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0);

        // Tap retained across clear: restart without cfg_load
        pulse(1'b0, 7'd0, 1'b1, 1'b0);
        send(8'b00000001);
        send(8'b10000001);
        chk("retained tap match", 32'(match_cnt), 32'd1);
        chk("retained tap err", 32'(err_cnt), 32'd0);

        // cfg_load in CHECK is ignored: the next prediction still uses the old tap
        pulse(1'b1, 7'b1000000, 1'b0, 1'b0);
        send(8'b11000001);
        send(8'b11100001);
        chk("check cfg_load match", 32'(match_cnt), 32'd3);
        chk("check cfg_load err", 32'(err_cnt), 32'd0);
        chk("check cfg_load hd", 32'(hd_sum), 32'd3);

        // clear with pat_valid and start in CHECK: not accepted, IDLE
        @(negedge clk);
        clear          = 1'b1;
        start          = 1'b1;
        u_if.pat_valid = 1'b1;
        u_if.pat_data  = 8'b11110001;
        #1;
        chk("clear ready", 32'(u_if.pat_ready), 32'd0);
        @(posedge clk);
        #1;
        clear          = 1'b0;
        start          = 1'b0;
        u_if.pat_valid = 1'b0;
        chk_all("clear prio", 2'b00, 16'd0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0);

        // Async reset mid-stream while pat_valid is high
        pulse(1'b0, 7'd0, 1'b1, 1'b0);
        send(8'b00000001);
        send(8'b10000001);
        send(8'b00000000);
        chk("pre-reset match", 32'(match_cnt), 32'd1);
        chk("pre-reset err", 32'(err_cnt), 32'd1);
        @(negedge clk);
        u_if.pat_valid = 1'b1;
        u_if.pat_data  = 8'b11111111;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", 2'b00, 16'd0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0);
        chk("async reset ready", 32'(u_if.pat_ready), 32'd0);
        u_if.pat_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tap lost on reset: with tap 0, nxt(00000001) = 10000000
        pulse(1'b0, 7'd0, 1'b1, 1'b0);
        send(8'b00000001);
        send(8'b10000001);
        chk("tap lost err", 32'(err_cnt), 32'd1);
        chk("tap lost match", 32'(match_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_pattern_checker.md
Name: lfsr_pattern_checker

Overview:
Consumer side of the LFSR pattern generator. Accepts the 8-bit patterns the generator produces (live or read back from pattern memory) over a valid/ready stream, and predicts each next pattern from the configured tap set. Counts matches and mismatches, tracks the Hamming distance between consecutive patterns, and raises lock and fail status for the test controller.

Parameters:
CNT_W, 16, width of match_cnt, err_cnt and hd_sum
MAX_ERR, 3, mismatch count at which the checker enters FAIL (1..2^CNT_W-1)
LOCK_RUN, 4, consecutive matches required to assert locked (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
tap_cfg  in  7  tap set [6:0]; same encoding as generator config_tap
cfg_load  in  1  latch tap_cfg; honoured only in IDLE
start  in  1  IDLE -> ACQUIRE
clear  in  1  synchronous return to IDLE from any state; clears counters
pat_valid  in  1  pattern present
pat_data  in  [0:7]  pattern; index 0 is the MSB (leftmost)
pat_ready  out  1  checker accepts pattern this cycle
state_o  out  2  00 IDLE, 01 ACQUIRE, 10 CHECK, 11 FAIL
match_cnt  out  CNT_W  accepted patterns equal to prediction
err_cnt  out  CNT_W  accepted patterns differing from prediction
hd_sum  out  CNT_W  sum of consecutive-pattern Hamming distances
last_hd  out  4  Hamming distance of the most recent pair (0..8)
locked  out  1  run of consecutive matches >= LOCK_RUN
fail  out  1  high while in FAIL

Behaviour:
- Reset: state IDLE. Tap register 0. Expected and previous-pattern registers 0. All counters, last_hd, the run counter, locked and fail are 0. pat_ready is 0.
- Accept: a pattern is accepted on a clock edge where pat_valid && pat_ready. pat_ready = (state==ACQUIRE || state==CHECK) && !clear, which is combinational from state and clear. A transfer is never lost: pat_data is sampled only on an accepted edge.
- Prediction function nxt(p), with t = tap register:
  - nxt[0] = p[7]
  - nxt[i] = p[i-1] ^ (t[7-i] & p[7]) for i = 1..7
- IDLE:
  - cfg_load latches tap_cfg.
  - start moves to ACQUIRE.
  - If cfg_load and start are both high, the tap is latched and the state still moves to ACQUIRE.
- ACQUIRE:
  - The first accepted pattern is not compared.
  - That edge does: expected <= nxt(pat); prev <= pat; state -> CHECK.
  - No counter changes.
- CHECK, on each accepted pattern:
  - Compare pat with expected. Equal: match_cnt+1 and run+1. Different: err_cnt+1 and run <= 0.
  - Self-resynchronise: expected <= nxt(pat), always derived from the received pattern.
  - last_hd <= popcount(pat ^ prev); hd_sum += that value; prev <= pat.
  - If the updated err_cnt == MAX_ERR, state -> FAIL on the same edge.
- FAIL: pat_ready = 0. Counters and last_hd hold, fail = 1. Only clear or reset leaves FAIL.
- locked = (run >= LOCK_RUN) && state==CHECK. The run counter is 8 bits and saturates at 255.
- Saturation: match_cnt, err_cnt and hd_sum saturate at 2^CNT_W-1 and never wrap.
- clear (synchronous, any state):
  - Next state IDLE. Counters, run, last_hd, expected and prev go to 0. The tap register is kept.
  - clear has priority over start, cfg_load and pat_valid in the same cycle.
- Reset mid-stream: immediate return to reset values regardless of pat_valid. The tap register is lost.
- Latency: all outputs are registered except pat_ready. Counters reflect an accepted pattern on the cycle after its acceptance edge.
- Taps change only through cfg_load in IDLE. cfg_load in any other state is ignored.

Test Plan:
1. Seed and match. cfg_load with tap=7'b0000001, start, then send 00000001, 10000001, 11000001 (bits written 0..7) -> state CHECK; match_cnt=2, err_cnt=0; last_hd=1 after the second pattern and 1 after the third; hd_sum=2.
2. Lock. Continue the test 1 stream with 11100001, 11110001 -> run=4, locked=1 on the cycle after the 4th match.
3. Mismatch and resync. Inject 00000000 where 11111001 is expected, then send nxt(00000000)=00000000 -> err_cnt=1, locked=0, and the following pattern counts as a match.
4. Fail. With MAX_ERR=3, send three corrupted patterns -> state FAIL, fail=1, pat_ready=0; further pat_valid is ignored and counters are frozen. clear -> IDLE with counters 0 and tap retained.
5. Backpressure and priority.
   - pat_valid held in IDLE -> nothing accepted.
   - clear and pat_valid together in CHECK -> pattern not accepted, state IDLE.
   - cfg_load in CHECK -> tap unchanged.
6. Async reset while pat_valid=1 mid-stream -> all outputs 0 immediately, without waiting for a clock edge; state IDLE.
